// File: rtl/mux8_1_tdm_scanner_if.sv
// Bus between a channel source and the 8:1 TDM scanner: scan request,
// eight 1-bit channels in, slot code / serial data / framing flags out.
interface mux8_1_tdm_scanner_if;
    logic en;
    logic D1, D2, D3, D4, D5, D6, D7, D8;
    logic S3, S2, S1;
    logic A;
    logic valid;
    logic frame_start;
    logic frame_done;

    modport master (
        output en, D1, D2, D3, D4, D5, D6, D7, D8,
        input  S3, S2, S1, A, valid, frame_start, frame_done
    );

    modport slave (
        input  en, D1, D2, D3, D4, D5, D6, D7, D8,
        output S3, S2, S1, A, valid, frame_start, frame_done
    );
endinterface

// File: rtl/mux8_1_tdm_scanner.sv
// Sequential 8:1 TDM scanner: snapshots D1..D8 and serialises them on A with
// the slot code on S3..S1, each slot held SLOT_CYCLES clocks, with frame flags.
module mux8_1_tdm_scanner #(
    parameter int SLOT_CYCLES = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    mux8_1_tdm_scanner_if.slave    bus
);

    localparam int            CW        = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(SLOT_CYCLES - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]    r_state;
    logic [2:0]    r_slot;
    logic [CW-1:0] r_hold;
    logic [7:0]    r_shadow;
    logic [2:0]    r_sel;
    logic          r_a;
    logic          r_valid;
    logic          r_fstart;
    logic          r_fdone;

    logic [7:0]    w_din;
    logic [0:0]    w_nstate;
    logic [2:0]    w_nslot;
    logic [CW-1:0] w_nhold;
    logic [7:0]    w_nshadow;
    logic          w_load;
    logic          w_nscan;
    logic          w_nlast;

    assign w_din = {bus.D8, bus.D7, bus.D6, bus.D5, bus.D4, bus.D3, bus.D2, bus.D1};

    // Next slot/hold position; a snapshot is taken from IDLE or at the end of a frame.
    always_comb begin
        w_nstate  = r_state;
        w_nslot   = r_slot;
        w_nhold   = r_hold;
        w_nshadow = r_shadow;
        w_load    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.en) begin
                    w_load    = 1'b1;
                    w_nstate  = ST_SCAN;
                    w_nslot   = 3'd0;
                    w_nhold   = '0;
                    w_nshadow = w_din;
                end
            end
            ST_SCAN: begin
                if (r_hold == HOLD_LAST) begin
                    w_nhold = '0;
                    if (r_slot == 3'd7) begin
                        w_nslot = 3'd0;
                        if (bus.en) begin
                            w_load    = 1'b1;
                            w_nshadow = w_din;
                        end else begin
                            w_nstate = ST_IDLE;
                        end
                    end else begin
                        w_nslot = r_slot + 3'd1;
                    end
                end else begin
                    w_nhold = r_hold + CW'(1);
                end
            end
            default: begin
                w_nstate = ST_IDLE;
                w_nslot  = 3'd0;
                w_nhold  = '0;
            end
        endcase
    end

    assign w_nscan = (w_nstate == ST_SCAN);
    assign w_nlast = (w_nslot == 3'd7) && (w_nhold == HOLD_LAST);

    // Outputs are computed from the next position so they are registered yet
    // line up with the slot they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_slot   <= 3'd0;
            r_hold   <= '0;
            r_shadow <= 8'b0;
            r_sel    <= 3'd0;
            r_a      <= 1'b0;
            r_valid  <= 1'b0;
            r_fstart <= 1'b0;
            r_fdone  <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_slot   <= w_nslot;
            r_hold   <= w_nhold;
            r_shadow <= w_nshadow;
            r_sel    <= w_nscan ? w_nslot : 3'd0;
            r_a      <= w_nscan & w_nshadow[w_nslot];
            r_valid  <= w_nscan;
            r_fstart <= w_load;
            r_fdone  <= w_nscan & w_nlast;
        end
    end

    assign bus.S3          = r_sel[2];
    assign bus.S2          = r_sel[1];
    assign bus.S1          = r_sel[0];
    assign bus.A           = r_a;
    assign bus.valid       = r_valid;
    assign bus.frame_start = r_fstart;
    assign bus.frame_done  = r_fdone;

endmodule

// File: doc/mux8_1_tdm_scanner.md
Name: mux8_1_tdm_scanner

Overview:
- Sequential 8-to-1 time-division multiplexer. It is the transmit end of the select/data link consumed by the 1:8 demultiplexer (inputs S3, S2, S1, A).
- Snapshots eight 1-bit channels D1..D8, then scans them onto the single line A.
- Drives the matching 3-bit slot code on S3..S1 so that a downstream 1:8 demux routes each bit back to Y1..Y8.
- Adds frame framing (valid, frame_start, frame_done) for link-level synchronisation.

Parameters:
- SLOT_CYCLES, 1, clock cycles each slot is held on the outputs. Legal range 1..256; slot counter width is max(1, clog2(SLOT_CYCLES)).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan request; sampled on rising clk edges.
- D1..D8  input  1 each  channel inputs; D1 maps to slot code 000, D8 to slot code 111.
- S3  output  1  slot code MSB.
- S2  output  1  slot code middle bit.
- S1  output  1  slot code LSB.
- A  output  1  serialized channel data for the current slot.
- valid  output  1  high while S3..S1 and A carry a live slot.
- frame_start  output  1  one-cycle pulse on the first cycle of slot 000.
- frame_done  output  1  one-cycle pulse on the last cycle of slot 111.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE, slot=0, hold counter=0, shadow register=8'b0.
  - S3=S2=S1=0, A=0, valid=0, frame_start=0, frame_done=0.
  - Release is synchronous to the next clk edge.
- All outputs are registered; there is no combinational path from any input to any output.
- States: IDLE, SCAN.
- IDLE:
  - Outputs are held at their reset values.
  - On an edge with en=1: shadow <= {D8..D1}, slot <= 0, hold <= 0, go to SCAN.
  - Outputs at that same edge: valid=1, S3..S1=000, A=D1 (as sampled at that edge), frame_start=1.
  - Latency: en high at edge k gives first slot data visible after edge k.
- SCAN:
  - Each slot lasts exactly SLOT_CYCLES cycles.
  - S3..S1 = slot index and A = shadow[slot] for the whole slot; both change only at slot boundaries.
  - Slot advances 0..7 in order and never skips.
- D1..D8 changes during a frame have no effect until the next snapshot; A always reflects the snapshot.
- frame_done is asserted for the final cycle of slot 7, coincident with S3..S1=111.
- End of frame (edge closing the last cycle of slot 7):
  - en=1: re-snapshot D1..D8 and continue directly with slot 0 (no gap cycle). frame_start pulses again, valid stays 1.
  - en=0: return to IDLE; all outputs return to 0 at that edge.
- en deasserted mid-frame does not abort the frame; the frame always completes all 8 slots.
- Reset asserted mid-frame aborts immediately. No partial-frame resume; the next frame needs a fresh en.
- SLOT_CYCLES=1: one slot per cycle, frame length 8 cycles, and frame_start/frame_done each last one cycle.
- Frame length is 8*SLOT_CYCLES cycles. Back-to-back frames give 100% valid duty.

Test Plan:
- Reset behaviour: rst_n=0 mid-SCAN at slot 3 -> all outputs 0 immediately, without waiting for clk. After release with en=0 -> outputs stay 0.
- Single frame, SLOT_CYCLES=1: {D8..D1}=8'b1010_0110, en pulsed for 1 cycle -> 8 cycles with valid=1.
  - S3..S1 = 000,001,...,111 and A = 0,1,1,0,0,1,0,1.
  - frame_start in cycle 1, frame_done in cycle 8, then IDLE with all outputs 0.
- Snapshot isolation: start a frame with D=8'hFF, then drive D=8'h00 at slot 2 -> A stays 1 for all 8 slots.
- Back-to-back frames: en held high, D=8'h0F then 8'hF0 at the frame boundary -> 16 contiguous valid cycles.
  - Second frame A = 0,0,0,0,1,1,1,1.
  - frame_start at cycles 1 and 9; no gap cycle.
- SLOT_CYCLES=3, D=8'b0000_0001 -> A=1 for cycles 1-3 with S=000, then 0 for 21 cycles. frame_done asserted only in cycle 24.
- Loopback: connect S3..S1 and A to a 1:8 demux with random D and 100 frames -> on each slot, Y(slot+1)=D(slot+1) and every other Y is 0.
